mem_port_arbiter: RTL

Arbitrates one single-port unified instruction/data memory between the CPU fetch requester (IF) and the load/store requester (DM). Each access is latched, presented to memory, and held until the memory acknowledges it or a timeout expires. The result is then returned to the winning requester with a one-cycle ready pulse. Sits between the CPU core and the unified memory, replacing the separate fetch and data memory paths. Used when the core runs multi-cycle and stalls on memory.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states,
// requester IDs and the access length codes used by the core's load/store decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// slave: the arbiter's view; master: the core and memory driving it.
interface mem_port_arbiter_if;

  logic        IF_req;
  logic [31:0] IF_addr;
  logic        IF_ready;
  logic [31:0] IF_rdata;

  logic        DM_req;
  logic        DM_we;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [1:0]  DM_length;
  logic        DM_signed;
  logic        DM_ready;
  logic [31:0] DM_rdata;

  logic        MEM_req;
  logic        MEM_we;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_wdata;
  logic [1:0]  MEM_length;
  logic        MEM_signed;
  logic        MEM_ack;
  logic [31:0] MEM_rdata;

  logic        BUS_error;

  modport slave (
    input  IF_req, IF_addr,
    input  DM_req, DM_we, DM_addr, DM_wdata, DM_length, DM_signed,
    input  MEM_ack, MEM_rdata,
    output IF_ready, IF_rdata, DM_ready, DM_rdata,
    output MEM_req, MEM_we, MEM_addr, MEM_wdata, MEM_length, MEM_signed,
    output BUS_error
  );

  modport master (
    output IF_req, IF_addr,
    output DM_req, DM_we, DM_addr, DM_wdata, DM_length, DM_signed,
    output MEM_ack, MEM_rdata,
    input  IF_ready, IF_rdata, DM_ready, DM_rdata,
    input  MEM_req, MEM_we, MEM_addr, MEM_wdata, MEM_length, MEM_signed,
    input  BUS_error
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (IF) and load/store (DM).
// Each access is latched, held until MEM_ack or timeout, then answered with a ready pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic SYS_clk,
  input  logic SYS_reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  req_id_e     last_grant_q;
  req_id_e     winner_q;
  req_id_e     grant_d;
  logic [7:0]  timer_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  mem_length_q;
  logic        mem_signed_q;

  logic        if_ready_q;
  logic        dm_ready_q;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        bus_error_q;

  logic        finish_d;
  logic        err_d;
  logic [31:0] result_d;

  always_comb begin
    grant_d = REQ_IF;
    if (bus.IF_req && bus.DM_req) begin
      grant_d = (last_grant_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (bus.DM_req) begin
      grant_d = REQ_DM;
    end
    // an ack on the last timer cycle still counts as a normal completion
    finish_d = bus.MEM_ack || (timer_q == TIMER_LAST);
    err_d    = !bus.MEM_ack;
    result_d = (bus.MEM_ack && !mem_we_q) ? bus.MEM_rdata : 32'd0;
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DM;
      winner_q     <= REQ_IF;
      timer_q      <= 8'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_length_q <= LEN_NONE;
      mem_signed_q <= 1'b0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
      bus_error_q  <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      bus_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.IF_req || bus.DM_req) begin
            last_grant_q <= grant_d;
            winner_q     <= grant_d;
            timer_q      <= 8'd0;
            mem_req_q    <= 1'b1;
            state_q      <= WAIT;
            if (grant_d == REQ_IF) begin
              mem_we_q     <= 1'b0;
              mem_addr_q   <= bus.IF_addr;
              mem_wdata_q  <= 32'd0;
              mem_length_q <= LEN_WORD;
              mem_signed_q <= 1'b0;
            end else begin
              mem_we_q     <= bus.DM_we;
              mem_addr_q   <= bus.DM_addr;
              mem_wdata_q  <= bus.DM_wdata;
              mem_length_q <= bus.DM_length;
              mem_signed_q <= bus.DM_signed;
            end
          end
        end
        WAIT: begin
          if (finish_d) begin
            mem_req_q   <= 1'b0;
            bus_error_q <= err_d;
            state_q     <= DONE;
            if (winner_q == REQ_IF) begin
              if_ready_q <= 1'b1;
              if_rdata_q <= result_d;
            end else begin
              dm_ready_q <= 1'b1;
              dm_rdata_q <= result_d;
            end
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.MEM_req    = mem_req_q;
  assign bus.MEM_we     = mem_we_q;
  assign bus.MEM_addr   = mem_addr_q;
  assign bus.MEM_wdata  = mem_wdata_q;
  assign bus.MEM_length = mem_length_q;
  assign bus.MEM_signed = mem_signed_q;
  assign bus.IF_ready   = if_ready_q;
  assign bus.IF_rdata   = if_rdata_q;
  assign bus.DM_ready   = dm_ready_q;
  assign bus.DM_rdata   = dm_rdata_q;
  assign bus.BUS_error  = bus_error_q;

endmodule
